// File: rtl/dte_ebus_diag_seq_pkg.sv
// Shared EBUS/DTE types for the diagnostic-cycle sequencer, its DTE
// front end and bus monitors.
package dte_ebus_diag_seq_pkg;

   localparam int EBUS_DS_W   = 7;
   localparam int EBUS_DATA_W = 36;

   typedef enum logic [2:0] {
      dteWrite           = 3'd0,
      dteDiagFunc        = 3'd1,
      dteRead            = 3'd2,
      dteReleaseEBUSData = 3'd3,
      dteMisc            = 3'd4
   } tReqType;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      RESP   = 3'd4
   } tDiagSeqState;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dte_ebus_diag_seq_tick_timer.sv
// Load/count/done down-counter shared by the setup, strobe and hold phases.
// done is high while the count sits at zero.
module diag_tick_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/dte_ebus_diag_seq.sv
// Timed EBUS diagnostic-cycle sequencer: one DTE request in, one timed
// ds/diagStrobe cycle on the bus, one captured word back to the DTE.
//
//  state  | meaning
//  IDLE   | waiting for a request; only state that accepts one
//  SETUP  | ds (and write data) settling before the strobe
//  STROBE | diagStrobe high; bus word captured on the last cycle
//  HOLD   | ds held after the strobe falls
//  RESP   | response presented, held until consumed
module dte_ebus_diag_seq
   import dte_ebus_diag_seq_pkg::*;
#(
   parameter int SETUP_TICKS  = 2,
   parameter int STROBE_TICKS = 4,
   parameter int HOLD_TICKS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reqValid,
   output logic                 reqReady,
   input  tReqType              reqType,
   input  logic [6:0]           reqFunc,
   input  logic [0:35]          reqData,
   output logic                 rspValid,
   input  logic                 rspReady,
   output logic [0:35]          rspData,
   output logic                 rspErr,
   output logic [EBUS_DS_W-1:0] ebusDs,
   output logic                 ebusDiagStrobe,
   output logic                 ebusDriving,
   output logic [0:35]          ebusDriveData,
   input  logic [0:35]          ebusData,
   output logic                 busy
);

   localparam int CNT_W = $clog2(max3(SETUP_TICKS, STROBE_TICKS, HOLD_TICKS) + 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_TICKS - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_TICKS - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_TICKS - 1);

   tDiagSeqState     state_q, state_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_done;
   logic             accept;
   logic             timed_req;

   assign accept    = reqValid && (state_q == IDLE);
   assign timed_req = (reqType == dteWrite) || (reqType == dteDiagFunc);

   diag_tick_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Timer is loaded on the transition edge, so each phase starts at N-1.
   always_comb begin
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      case (state_q)
         IDLE: begin
            if (reqValid) begin
               if (timed_req) begin
                  state_d      = SETUP;
                  tmr_load     = 1'b1;
                  tmr_load_val = SETUP_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         SETUP: begin
            if (tmr_done) begin
               state_d      = STROBE;
               tmr_load     = 1'b1;
               tmr_load_val = STROBE_LOAD;
            end
         end
         STROBE: begin
            if (tmr_done) begin
               state_d      = HOLD;
               tmr_load     = 1'b1;
               tmr_load_val = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (tmr_done)
               state_d = RESP;
         end
         RESP: begin
            if (rspReady)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      reqReady       = (state_q == IDLE);
      busy           = (state_q != IDLE);
      rspValid       = (state_q == RESP);
      ebusDiagStrobe = (state_q == STROBE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ebusDs        <= '0;
         ebusDriving   <= 1'b0;
         ebusDriveData <= '0;
         rspData       <= '0;
         rspErr        <= 1'b0;
      end else begin
         if (accept) begin
            case (reqType)
               dteWrite: begin
                  ebusDs        <= reqFunc;
                  ebusDriving   <= 1'b1;
                  ebusDriveData <= reqData;
               end
               dteDiagFunc: ebusDs <= reqFunc;
               dteRead:     rspData <= ebusData;
               dteReleaseEBUSData: begin
                  ebusDriving   <= 1'b0;
                  ebusDriveData <= '0;
                  rspData       <= ebusData;
               end
               default: begin
                  rspErr  <= 1'b1;
                  rspData <= '0;
               end
            endcase
         end
         if (state_q == STROBE && tmr_done)
            rspData <= ebusData;
         if (state_q == HOLD && tmr_done)
            ebusDs <= '0;
         if (state_q == RESP && rspReady)
            rspErr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dte_ebus_diag_seq.sv
// Scoreboard bench for dte_ebus_diag_seq: per-cycle bus profile checks and
// queued expected responses compared at each response handshake.
`timescale 1ns/1ps
module tb_dte_ebus_diag_seq;
   import dte_ebus_diag_seq_pkg::*;

   localparam int S = 2;
   localparam int T = 4;
   localparam int H = 2;

   typedef struct {
      logic [0:35] data;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid;
   logic        reqReady;
   tReqType     reqType;
   logic [6:0]  reqFunc;
   logic [0:35] reqData;
   logic        rspValid;
   logic        rspReady;
   logic [0:35] rspData;
   logic        rspErr;
   logic [6:0]  ebusDs;
   logic        ebusDiagStrobe;
   logic        ebusDriving;
   logic [0:35] ebusDriveData;
   logic [0:35] ebusData;
   logic        busy;

   int   n_cmp = 0;
   int   n_err = 0;
   rsp_t sb_q[$];
   logic        drv_exp = 1'b0;
   logic [0:35] drvd_exp = '0;

   always #8.333 clk = ~clk;

   dte_ebus_diag_seq #(.SETUP_TICKS(S), .STROBE_TICKS(T), .HOLD_TICKS(H)) dut (
      .clk(clk), .reset(reset),
      .reqValid(reqValid), .reqReady(reqReady), .reqType(reqType),
      .reqFunc(reqFunc), .reqData(reqData),
      .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
      .ebusDs(ebusDs), .ebusDiagStrobe(ebusDiagStrobe), .ebusDriving(ebusDriving),
      .ebusDriveData(ebusDriveData), .ebusData(ebusData), .busy(busy)
   );

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %o expected %o", tag, got, exp);
      end
   endtask

   // ebusData at cycle c is base+c, so the captured word pins down the sample edge.
   task automatic run_req(input tReqType typ, input logic [6:0] func, input logic [0:35] data,
                          input logic [0:35] base, input int hold);
      logic timed;
      int   rsp_cyc;
      rsp_t e;
      rsp_t got_e;
      bit   done;
      timed   = (typ == dteWrite) || (typ == dteDiagFunc);
      rsp_cyc = timed ? S + T + H + 1 : 1;
      @(negedge clk);
      check("req_ready_idle", reqReady, 1);
      reqValid = 1'b1; reqType = typ; reqFunc = func; reqData = data; ebusData = base;
      @(posedge clk);
      e.err  = !(timed || typ == dteRead || typ == dteReleaseEBUSData);
      e.data = timed ? base + 36'(S + T) : (e.err ? '0 : base);
      sb_q.push_back(e);
      if (typ == dteWrite) begin drv_exp = 1'b1; drvd_exp = data; end
      if (typ == dteReleaseEBUSData) begin drv_exp = 1'b0; drvd_exp = '0; end
      done = 0;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk);
         reqValid = 1'b0;
         check("ds", ebusDs, (timed && c <= S + T + H) ? 36'(func) : 36'd0);
         check("strobe", ebusDiagStrobe, (timed && c > S && c <= S + T) ? 1 : 0);
         check("driving", ebusDriving, drv_exp);
         check("drive_data", ebusDriveData, drvd_exp);
         if (rspValid) begin
            check("rsp_cycle", 36'(c), 36'(rsp_cyc));
            for (int h = 0; h < hold; h++) begin
               check("hold_rsp_valid", rspValid, 1);
               check("hold_req_ready", reqReady, 0);
               check("hold_rsp_err", rspErr, e.err);
               @(negedge clk);
            end
            if (sb_q.size() == 0) begin
               check("sb_empty", 1, 0);
            end else begin
               got_e = sb_q.pop_front();
               check("rsp_data", rspData, got_e.data);
               check("rsp_err", rspErr, got_e.err);
            end
            rspReady = 1'b1;
            @(posedge clk);
            #1 rspReady = 1'b0;
            done = 1;
         end else begin
            ebusData = base + 36'(c);
         end
      end
      if (!done) check("rsp_timeout", 0, 1);
   endtask

   initial begin
      reset = 1'b1; reqValid = 1'b0; reqType = dteRead; reqFunc = '0; reqData = '0;
      rspReady = 1'b0; ebusData = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ds", ebusDs, 0);
      check("rst_strobe", ebusDiagStrobe, 0);
      check("rst_rsp_valid", rspValid, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;

      run_req(dteDiagFunc, 7'o71, 36'o0, 36'o777000_000771, 0);
      run_req(dteRead, 7'o5, 36'o0, 36'o1, 0);
      run_req(dteWrite, 7'o42, 36'o123456_654321, 36'o100, 0);
      run_req(dteWrite, 7'o13, 36'o707070_070707, 36'o2000, 0);
      run_req(dteReleaseEBUSData, 7'o0, 36'o0, 36'o555, 0);
      run_req(dteMisc, 7'o42, 36'o777, 36'o3333, 5);

      // Reset in cycle 4 of a write: everything drops, nothing is answered.
      @(negedge clk);
      reqValid = 1'b1; reqType = dteWrite; reqFunc = 7'o42; reqData = 36'o1234;
      @(posedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         reqValid = 1'b0;
      end
      check("pre_rst_strobe", ebusDiagStrobe, 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drv_exp = 1'b0; drvd_exp = '0;
      check("mid_rst_strobe", ebusDiagStrobe, 0);
      check("mid_rst_ds", ebusDs, 0);
      check("mid_rst_driving", ebusDriving, 0);
      check("mid_rst_req_ready", reqReady, 1);
      for (int c = 0; c < 10; c++) begin
         check("mid_rst_no_rsp", rspValid, 0);
         @(negedge clk);
      end

      run_req(dteRead, 7'o0, 36'o0, 36'o4242, 0);
      check("sb_drained", 36'(sb_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
